jk_mod_counter: RTL and testbench
=================================

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 Parameter MODULUS, default 16, count modulus; legal range 2..2**WIDTH; illegal values SHALL stop elaboration with an error.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count/load enable; low = hold.
REQ-006 mode  input  2  00 hold, 01 count up, 10 count down, 11 parallel load.
REQ-007 load_val  input  WIDTH  value captured when mode = 11.
REQ-008 q  output  WIDTH  registered count value.
REQ-009 tc  output  1  combinational terminal count: (mode=01 and q=MODULUS-1) or (mode=10 and q=0), regardless of en.
REQ-010 wrap  output  1  registered one-cycle pulse, high in the cycle after q wraps.

Function
REQ-011 Every state bit SHALL be held in a JK cell; next state SHALL be produced only by driving that cell's J/K inputs, never by a direct D path.
REQ-012 en=0: q and all cells SHALL hold (J=K=0); wrap SHALL be 0 next cycle.
REQ-013 en=1, mode=00: q SHALL hold; wrap 0.
REQ-014 en=1, mode=01: q SHALL become q+1 one cycle later; if q=MODULUS-1, q SHALL become 0 and wrap SHALL be 1 in that next cycle.
REQ-015 en=1, mode=10: q SHALL become q-1; if q=0, q SHALL become MODULUS-1 and wrap SHALL be 1 in that next cycle.
REQ-016 en=1, mode=11: q SHALL become load_val (per bit J=d, K=~d); if load_val >= MODULUS, q SHALL become MODULUS-1; wrap 0.
REQ-017 Any q value >= MODULUS (unreachable except via X/fault) SHALL be treated as MODULUS-1 for counting and tc.
REQ-018 Count/load latency SHALL be exactly one clock; wrap SHALL coincide with the wrapped q value.
REQ-019 For MODULUS=2**WIDTH the wrap SHALL be natural binary rollover with identical wrap timing.
REQ-020 Mode changes SHALL take effect on the first edge at which they are sampled; no pipelining of mode.

Reset
REQ-021 reset=1 SHALL force q=0 and wrap=0 immediately, independent of clk.
REQ-022 While reset=1, en/mode/load_val SHALL be ignored; tc SHALL still reflect mode and q=0.
REQ-023 On reset deassertion, the first rising edge with en=1 SHALL act normally from q=0; reset asserted mid-count SHALL abandon the count with no wrap pulse.

Structure
REQ-024 Shared package SHALL hold mode encodings (HOLD, UP, DOWN, LOAD) and a width-check function.
REQ-025 One sub-module jk_cell: single JK flip-flop with clk, reset (async, active-high, clears to 0), j, k, q; hold/reset/set/toggle per JK truth table.
REQ-026 jk_mod_counter SHALL instantiate WIDTH jk_cell instances via generate plus one plain register for wrap.
REQ-027 Target size 120-400 RTL lines across both modules.

Verification
REQ-028 Reset: assert reset mid-count at q=5 between edges -> q=0, wrap=0 before next edge; release, en=1, mode=01 -> q=1 after one edge.
REQ-029 Up wrap, WIDTH=4, MODULUS=10: count from 0 for 10 edges -> q sequence 1..9,0; tc high while q=9; wrap high only in cycle q=0.
REQ-030 Down wrap, MODULUS=10: load 1, then mode=10 for 3 edges -> q 0,9,8; wrap high only in cycle q=9; tc high while q=0.
REQ-031 Load clamp, MODULUS=10: load_val=13 -> q=9; load_val=6 -> q=6; wrap stays 0.
REQ-032 Hold: q=7, toggle mode among 00/01 with en=0 for 4 edges -> q stays 7, wrap 0; tc follows mode.
REQ-033 Full-range, WIDTH=3, MODULUS=8: 16 up edges -> two rollovers 7->0, exactly two wrap pulses; compare every cycle against a behavioural mod-counter model.

Source files
------------

// File: rtl/jk_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// jk_mod_counter_pkg
// Definitions shared by the JK-cell modulo counter, its bus interface and any
// code that drives it:
//   mode_e        - 2-bit operating mode encoding (HOLD, UP, DOWN, LOAD)
//   MIN_WIDTH     - smallest supported counter width
//   MAX_WIDTH     - largest supported counter width
//   params_legal  - elaboration-time check of a WIDTH / MODULUS pair
// -----------------------------------------------------------------------------
package jk_mod_counter_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10,
      LOAD = 2'b11
   } mode_e;

   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 16;

   // A modulus is legal when 2 <= modulus <= 2**width and the width itself is
   // inside the supported range.
   function automatic bit params_legal(input int width, input int modulus);
      if (width < MIN_WIDTH || width > MAX_WIDTH) begin
         return 1'b0;
      end
      if (modulus < 2 || modulus > (1 << width)) begin
         return 1'b0;
      end
      return 1'b1;
   endfunction

endpackage : jk_mod_counter_pkg

// File: rtl/jk_mod_counter_if.sv
// -----------------------------------------------------------------------------
// jk_mod_counter_if
// Control and status bundle of the modulo counter.
//   en        - count/load enable, low holds the counter
//   mode      - HOLD / UP / DOWN / LOAD
//   load_val  - value captured in LOAD mode
//   q         - registered count value
//   tc        - combinational terminal count
//   wrap      - registered one-cycle pulse in the cycle after a wrap
// Modports:
//   master - drives en/mode/load_val, observes q/tc/wrap
//   slave  - the counter itself
// -----------------------------------------------------------------------------
interface jk_mod_counter_if #(
   parameter int WIDTH = 4
);
   import jk_mod_counter_pkg::*;

   logic             en;
   mode_e            mode;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;

   modport master (
      output en,
      output mode,
      output load_val,
      input  q,
      input  tc,
      input  wrap
   );

   modport slave (
      input  en,
      input  mode,
      input  load_val,
      output q,
      output tc,
      output wrap
   );

endinterface : jk_mod_counter_if

// File: rtl/jk_mod_counter_jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
// Single JK flip-flop, the storage element of every counter bit.
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; clears the cell to 0
//   j, k   - JK controls: 00 hold, 01 clear, 10 set, 11 toggle
//   q      - cell state
// -----------------------------------------------------------------------------
module jk_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   logic state_q;

   // NOTE: the reset term is in the sensitivity list, so the cell clears as
   // soon as reset rises instead of waiting for the next clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every cell samples the old state
         // of its neighbours; blocking here would create order-dependent races.
         case ({j, k})
            2'b00:   state_q <= state_q;
            2'b01:   state_q <= 1'b0;
            2'b10:   state_q <= 1'b1;
            default: state_q <= ~state_q;
         endcase
      end
   end

   assign q = state_q;

endmodule : jk_cell

// File: rtl/jk_mod_counter.sv
// -----------------------------------------------------------------------------
// jk_mod_counter
// Up/down modulo-MODULUS counter with parallel load, built from WIDTH JK cells.
// The next count is computed behaviourally and then translated into J/K
// controls for each cell; no cell is ever loaded through a D input.
// Parameters:
//   WIDTH    - counter width, 2..16
//   MODULUS  - count modulus, 2..2**WIDTH (checked at elaboration)
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; q=0, wrap=0 immediately
//   bus    - jk_mod_counter_if slave (en, mode, load_val, q, tc, wrap)
// -----------------------------------------------------------------------------
module jk_mod_counter
   import jk_mod_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic           clk,
   input  logic           reset,
   jk_mod_counter_if.slave bus
);

   // Illegal parameter pairs stop elaboration.
   if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
      $error("jk_mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
   end

   // One extra bit so MODULUS = 2**WIDTH is representable for comparisons.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] count_q;       // state held in the JK cells
   logic [WIDTH-1:0] count_d;       // desired next state
   logic [WIDTH-1:0] count_eff;     // count_q with out-of-range values clamped
   logic [WIDTH-1:0] load_clamped;  // load_val with out-of-range values clamped
   logic [WIDTH-1:0] cell_j;
   logic [WIDTH-1:0] cell_k;
   logic             wrap_q;
   logic             wrap_d;

   // A value at or above MODULUS can only come from a fault; treat it as the
   // top of the range so counting and tc recover cleanly.
   assign count_eff    = ({1'b0, count_q} >= MOD_EXT) ? MAX_VAL : count_q;
   assign load_clamped = ({1'b0, bus.load_val} >= MOD_EXT) ? MAX_VAL : bus.load_val;

   // Next-state and wrap-detect logic.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave it unassigned, which would otherwise infer a latch.
      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.en) begin
         case (bus.mode)
            UP: begin
               if (count_eff == MAX_VAL) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_eff + ONE;
               end
            end
            DOWN: begin
               if (count_eff == '0) begin
                  count_d = MAX_VAL;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_eff - ONE;
               end
            end
            LOAD: begin
               count_d = load_clamped;
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
   end

   // Translate the desired state into JK controls: J=d, K=~d forces each cell
   // to d on the edge; J=K=0 holds it.
   always_comb begin
      cell_j = '0;
      cell_k = '0;
      if (bus.en && (bus.mode != HOLD)) begin
         cell_j = count_d;
         cell_k = ~count_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cells
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (cell_j[i]),
         .k     (cell_k[i]),
         .q     (count_q[i])
      );
   end

   // Wrap flag: registered so it lines up with the wrapped count value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   // Terminal count depends only on mode and the current count, not on en.
   assign bus.tc   = ((bus.mode == UP)   && (count_eff == MAX_VAL)) ||
                     ((bus.mode == DOWN) && (count_eff == '0));
   assign bus.q    = count_q;
   assign bus.wrap = wrap_q;

endmodule : jk_mod_counter

// File: tb/tb_jk_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_mod_counter
// Drives two counter instances: dut_a (WIDTH=4, MODULUS=10) and dut_b
// (WIDTH=3, MODULUS=8, natural binary rollover). Inputs change on the falling
// edge; expected q/wrap are queued when stimulus is applied and compared one
// rising edge later; tc is compared combinationally before the edge.
// -----------------------------------------------------------------------------
module tb_jk_mod_counter;
   import jk_mod_counter_pkg::*;

   localparam int MOD_A = 10;
   localparam int MOD_B = 8;

   logic clk;
   logic reset;

   jk_mod_counter_if #(.WIDTH(4)) bus_a ();
   jk_mod_counter_if #(.WIDTH(3)) bus_b ();

   jk_mod_counter #(.WIDTH(4), .MODULUS(MOD_A)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   jk_mod_counter #(.WIDTH(3), .MODULUS(MOD_B)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   typedef struct {
      int    q;
      bit    wrap;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   vectors      = 0;
   int   miscompares  = 0;
   int   model_a      = 0;
   int   model_b      = 0;
   int   wraps_seen_b = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int clamp(input int v, input int modulus);
      return (v >= modulus) ? modulus - 1 : v;
   endfunction

   function automatic bit model_tc(input int modulus, input int cur, input mode_e m);
      int c;
      c = clamp(cur, modulus);
      return ((m == UP) && (c == modulus - 1)) || ((m == DOWN) && (c == 0));
   endfunction

   task automatic model_next(input int modulus, input int cur, input mode_e m,
                             input bit en, input int ld,
                             output int nxt, output bit w);
      int c;
      c   = clamp(cur, modulus);
      nxt = cur;
      w   = 1'b0;
      if (en) begin
         case (m)
            UP:      if (c == modulus - 1) begin nxt = 0; w = 1'b1; end else nxt = c + 1;
            DOWN:    if (c == 0) begin nxt = modulus - 1; w = 1'b1; end else nxt = c - 1;
            LOAD:    nxt = clamp(ld, modulus);
            default: nxt = cur;
         endcase
      end
   endtask

   // One clock of stimulus on dut_a (on_b=0) or dut_b (on_b=1). Entered and
   // left on a falling edge.
   task automatic step(input bit on_b, input mode_e m, input bit en,
                       input int ld, input string tag);
      int         cur;
      int         nxt;
      int         modulus;
      bit         w;
      logic       tc_obs;
      logic       wrap_obs;
      logic [15:0] q_obs;
      exp_t       e;
      modulus = on_b ? MOD_B : MOD_A;
      cur     = on_b ? model_b : model_a;
      if (on_b) begin
         bus_b.mode = m; bus_b.en = en; bus_b.load_val = 3'(ld);
      end else begin
         bus_a.mode = m; bus_a.en = en; bus_a.load_val = 4'(ld);
      end
      #1;
      tc_obs = on_b ? bus_b.tc : bus_a.tc;
      vectors++;
      if (tc_obs !== model_tc(modulus, cur, m)) begin
         miscompares++;
         $display("FAIL %s tc: got %b expected %b (q=%0d mode=%0d)",
                  tag, tc_obs, model_tc(modulus, cur, m), cur, m);
      end
      model_next(modulus, cur, m, en, ld, nxt, w);
      sb.push_back('{nxt, w, tag});
      if (on_b) model_b = nxt; else model_a = nxt;

      @(posedge clk);
      #1;
      e        = sb.pop_front();
      q_obs    = on_b ? 16'(bus_b.q) : 16'(bus_a.q);
      wrap_obs = on_b ? bus_b.wrap : bus_a.wrap;
      vectors++;
      if (q_obs !== 16'(e.q)) begin
         miscompares++;
         $display("FAIL %s q: got %0d expected %0d", e.tag, q_obs, e.q);
      end
      vectors++;
      if (wrap_obs !== e.wrap) begin
         miscompares++;
         $display("FAIL %s wrap: got %b expected %b", e.tag, wrap_obs, e.wrap);
      end
      if (on_b && (wrap_obs === 1'b1)) wraps_seen_b++;
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      bus_a.en = 1'b0; bus_a.mode = HOLD; bus_a.load_val = '0;
      bus_b.en = 1'b0; bus_b.mode = HOLD; bus_b.load_val = '0;
      #2;
      vectors++;
      if (bus_a.q !== 4'd0) begin miscompares++; $display("FAIL por_a q: got %0d expected 0", bus_a.q); end
      vectors++;
      if (bus_a.wrap !== 1'b0) begin miscompares++; $display("FAIL por_a wrap: got %b expected 0", bus_a.wrap); end
      vectors++;
      if (bus_b.q !== 3'd0) begin miscompares++; $display("FAIL por_b q: got %0d expected 0", bus_b.q); end
      vectors++;
      if (bus_b.wrap !== 1'b0) begin miscompares++; $display("FAIL por_b wrap: got %b expected 0", bus_b.wrap); end

      @(negedge clk);
      reset = 1'b0;
      model_a = 0;
      model_b = 0;
      step(0, LOAD, 1'b1, 4, "rst_load4");
      step(0, UP,   1'b1, 0, "rst_up5");

      // Reset between edges while counting at q=5.
      bus_a.mode = UP; bus_a.en = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      model_a = 0;
      vectors++;
      if (bus_a.q !== 4'd0) begin miscompares++; $display("FAIL rst_mid q: got %0d expected 0", bus_a.q); end
      vectors++;
      if (bus_a.wrap !== 1'b0) begin miscompares++; $display("FAIL rst_mid wrap: got %b expected 0", bus_a.wrap); end

      // While reset is held the inputs are ignored but tc still follows mode.
      bus_a.mode = DOWN;
      #1;
      vectors++;
      if (bus_a.tc !== 1'b1) begin miscompares++; $display("FAIL rst_tc_down tc: got %b expected 1", bus_a.tc); end
      @(posedge clk);
      #1;
      vectors++;
      if (bus_a.q !== 4'd0) begin miscompares++; $display("FAIL rst_held q: got %0d expected 0", bus_a.q); end
      @(negedge clk);
      reset = 1'b0;
      step(0, UP, 1'b1, 0, "rst_release_up");

      // Reset right after a wrap clears the pulse immediately.
      step(0, LOAD, 1'b1, 9, "rst_load9");
      step(0, UP,   1'b1, 0, "rst_wrap_up");
      reset = 1'b1;
      #1;
      model_a = 0;
      vectors++;
      if (bus_a.wrap !== 1'b0) begin miscompares++; $display("FAIL rst_wrap wrap: got %b expected 0", bus_a.wrap); end
      @(negedge clk);
      reset = 1'b0;
      bus_a.en = 1'b0;
   endtask

   task automatic test_up_wrap();
      step(0, LOAD, 1'b1, 0, "up_load0");
      for (int i = 1; i <= 10; i++) begin
         step(0, UP, 1'b1, 0, $sformatf("up_%0d", i));
      end
      step(0, UP, 1'b0, 0, "up_after_wrap_en0");
   endtask

   task automatic test_down_wrap();
      step(0, LOAD, 1'b1, 1, "dn_load1");
      for (int i = 1; i <= 3; i++) begin
         step(0, DOWN, 1'b1, 0, $sformatf("dn_%0d", i));
      end
   endtask

   task automatic test_load_clamp();
      int vals[6] = '{13, 6, 10, 9, 15, 0};
      foreach (vals[i]) begin
         step(0, LOAD, 1'b1, vals[i], $sformatf("load_%0d", vals[i]));
      end
   endtask

   task automatic test_hold();
      step(0, LOAD, 1'b1, 7, "hold_load7");
      for (int i = 0; i < 4; i++) begin
         step(0, (i % 2 == 1) ? UP : HOLD, 1'b0, 3, $sformatf("hold_en0_%0d", i));
      end
      step(0, HOLD, 1'b1, 2, "hold_en1_mode00");
      step(0, LOAD, 1'b1, 9, "hold_load9");
      step(0, UP,   1'b0, 0, "hold_tc_up");
      step(0, DOWN, 1'b0, 0, "hold_tc_down");
      step(0, LOAD, 1'b1, 0, "hold_load0");
      step(0, DOWN, 1'b0, 0, "hold_tc_down0");
      step(0, UP,   1'b0, 0, "hold_tc_up0");
   endtask

   task automatic test_back_to_back();
      mode_e m;
      for (int i = 0; i < 40; i++) begin
         m = mode_e'($urandom_range(0, 3));
         step(0, m, ($urandom_range(0, 7) != 0), int'($urandom_range(0, 15)),
              $sformatf("b2b_%0d", i));
      end
   endtask

   task automatic test_full_range();
      wraps_seen_b = 0;
      for (int i = 1; i <= 16; i++) begin
         step(1, UP, 1'b1, 0, $sformatf("full_up_%0d", i));
      end
      vectors++;
      if (wraps_seen_b != 2) begin
         miscompares++;
         $display("FAIL full_wrap_count: got %0d expected 2", wraps_seen_b);
      end
      step(1, DOWN, 1'b1, 0, "full_down_rollunder");
      step(1, LOAD, 1'b1, 7, "full_load7");
      step(1, UP,   1'b1, 0, "full_up_from7");
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load_clamp();
      test_hold();
      test_back_to_back();
      test_full_range();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_jk_mod_counter
